// File: rtl/ste_avg_iir_mc_if.sv
// Sample-in / average-out bundle for ste_avg_iir_mc: the sequencer drives
// through the master modport and the averager answers on the slave modport.
interface ste_avg_iir_mc_if #(
  parameter int DATA_W    = 16,
  parameter int CH_N      = 4,
  parameter int MAX_SHIFT = 8
);
  localparam int CH_W = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int SH_W = $clog2(MAX_SHIFT + 1);

  logic [DATA_W-1:0] din_i;
  logic              din_valid_i;
  logic [CH_W-1:0]   din_ch_i;
  logic [SH_W-1:0]   shift_i;
  logic              avg_clr_i;
  logic              avg_en_i;
  logic [DATA_W-1:0] dout_o;
  logic [CH_W-1:0]   dout_ch_o;
  logic              dout_update_o;

  modport master (
    output din_i, din_valid_i, din_ch_i, shift_i, avg_clr_i, avg_en_i,
    input  dout_o, dout_ch_o, dout_update_o
  );

  modport slave (
    input  din_i, din_valid_i, din_ch_i, shift_i, avg_clr_i, avg_en_i,
    output dout_o, dout_ch_o, dout_update_o
  );
endinterface

// File: rtl/ste_avg_iir_mc.sv
// Time-multiplexed per-channel exponential averager, alpha = 2^-k.
// Optional macro AVG_ROUND_EN selects round-half-up with saturation instead of truncation.
module ste_avg_iir_mc #(
  parameter int DATA_W    = 16,
  parameter int CH_N      = 4,
  parameter int MAX_SHIFT = 8
) (
  input logic             clk,
  input logic             rst,
  ste_avg_iir_mc_if.slave bus
);
  localparam int CH_W  = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int SH_W  = $clog2(MAX_SHIFT + 1);
  localparam int ACC_W = DATA_W + MAX_SHIFT;

  localparam logic [SH_W-1:0]   K_MAX  = SH_W'(MAX_SHIFT);
  localparam logic [CH_W:0]     CH_LIM = (CH_W + 1)'(CH_N);
  localparam logic [DATA_W-1:0] D_MAX  = '1;

  logic [ACC_W-1:0]  acc [CH_N];
  logic [CH_N-1:0]   primed;
  logic [SH_W-1:0]   k_reg;

  logic [SH_W-1:0]   k_eff;
  logic              take;
  logic              k_change;
  logic              do_avg;
  logic [ACC_W-1:0]  acc_cur;
  logic [ACC_W-1:0]  din_ext;
  logic [ACC_W-1:0]  acc_new;
  logic [DATA_W-1:0] avg_out;
  logic [DATA_W-1:0] out_val;
  logic [CH_N-1:0]   primed_nxt;
`ifdef AVG_ROUND_EN
  logic [ACC_W:0]    rnd_sum;
  logic [ACC_W:0]    rnd_q;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    k_eff    = (bus.shift_i > K_MAX) ? K_MAX : bus.shift_i;
    take     = bus.din_valid_i && ({1'b0, bus.din_ch_i} < CH_LIM);
    k_change = (k_eff != k_reg);
    acc_cur  = acc[bus.din_ch_i];
    din_ext  = ACC_W'(bus.din_i);

    // A clear or a new k invalidates the history even for the sample arriving now.
    do_avg  = primed[bus.din_ch_i] && !bus.avg_clr_i && !k_change && bus.avg_en_i;
    acc_new = do_avg ? (acc_cur - (acc_cur >> k_eff) + din_ext) : (din_ext << k_eff);

`ifdef AVG_ROUND_EN
    rnd_sum = {1'b0, acc_new} +
              ((k_eff == '0) ? '0 : ((ACC_W + 1)'(1) << (k_eff - 1'b1)));
    rnd_q   = rnd_sum >> k_eff;
    avg_out = (rnd_q > (ACC_W + 1)'(D_MAX)) ? D_MAX : rnd_q[DATA_W-1:0];
`else
    avg_out = DATA_W'(acc_new >> k_eff);
`endif
    out_val = do_avg ? avg_out : bus.din_i;

    // Bypass still preloads the accumulator, so the channel counts as primed and
    // re-enabling continues from the last raw value.
    primed_nxt = primed;
    if (bus.avg_clr_i || (take && k_change)) primed_nxt = '0;
    if (take) primed_nxt[bus.din_ch_i] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the accumulator array is reset explicitly because a stale history must
      // never leak into the first average after reset.
      for (int c = 0; c < CH_N; c++) acc[c] <= '0;
      primed            <= '0;
      k_reg             <= '0;
      bus.dout_o        <= '0;
      bus.dout_ch_o     <= '0;
      bus.dout_update_o <= 1'b0;
    end else begin
      primed            <= primed_nxt;
      bus.dout_update_o <= take;
      if (take) begin
        acc[bus.din_ch_i] <= acc_new;
        k_reg             <= k_eff;
        bus.dout_o        <= out_val;
        bus.dout_ch_o     <= bus.din_ch_i;
      end
    end
  end
endmodule
